// File: rtl/apf_wishbone_slave_if.sv
// rtl/apf_wishbone_slave_if.sv - Wishbone B4 slave bus bundle with master/slave views
interface apf_wishbone_slave_if;
   logic [29:0] addr;
   logic [1:0]  bte;
   logic [2:0]  cti;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] data_write;
   logic [31:0] data_read;
   logic        ack;
   logic        err;

   modport master (
      output addr, bte, cti, cyc, stb, we, sel, data_write,
      input  data_read, ack, err
   );

   modport slave (
      input  addr, bte, cti, cyc, stb, we, sel, data_write,
      output data_read, ack, err
   );
endinterface

// File: rtl/apf_wishbone_slave.sv
// rtl/apf_wishbone_slave.sv - Wishbone RAM slave, 2^ADDR_WIDTH x 32, byte lanes
// Incrementing bursts (cti=010, bte=00) are enabled by defining APF_WB_SLAVE_BURST_EN.
module apf_wishbone_slave #(
   parameter int          ADDR_WIDTH = 8,
   parameter logic [29:0] BASE_ADDR  = 30'h0
) (
   input logic                 clk_sys,
   input logic                 reset,
   apf_wishbone_slave_if.slave wb
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef APF_WB_SLAVE_BURST_EN
   typedef enum logic [1:0] {IDLE, ACK, ERR, BURST} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACK, ERR} state_t;
`endif

   state_t                state_q, state_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [31:0]           data_read_q, data_read_d;
   logic [ADDR_WIDTH-1:0] off_q, off_d;
   logic [ADDR_WIDTH-1:0] req_off;
   logic [31:0]           ram_q [DEPTH];
   logic                  req;
   logic                  hit;
   logic                  wr_en;

   assign req     = wb.cyc & wb.stb;
   assign hit     = (wb.addr[29:ADDR_WIDTH] == BASE_ADDR[29:ADDR_WIDTH]);
   assign req_off = wb.addr[ADDR_WIDTH-1:0];

`ifdef APF_WB_SLAVE_BURST_EN
   logic [ADDR_WIDTH-1:0] off_nxt;
   assign off_nxt = off_q + ADDR_WIDTH'(1);
`else
   logic unused_burst_ctl;
   assign unused_burst_ctl = ^{wb.cti, wb.bte};
`endif

   always_comb begin
      state_d     = state_q;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      data_read_d = 32'h0;
      off_d       = off_q;
      wr_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  off_d       = req_off;
                  data_read_d = ram_q[req_off];
                  ack_d       = 1'b1;
                  state_d     = ACK;
`ifdef APF_WB_SLAVE_BURST_EN
                  if (wb.cti == 3'b010 && wb.bte == 2'b00) begin
                     state_d = BURST;
                  end
`endif
               end else begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end
            end
         end
         // A classic ack always falls back to IDLE, so a held request acks every other cycle.
         ACK: begin
            wr_en   = req & wb.we;
            state_d = IDLE;
         end
         ERR: begin
            state_d = IDLE;
         end
`ifdef APF_WB_SLAVE_BURST_EN
         // Next beat's word is fetched while the current beat is being acked.
         BURST: begin
            wr_en = req & wb.we;
            if (req && wb.cti != 3'b111) begin
               off_d       = off_nxt;
               data_read_d = ram_q[off_nxt];
               ack_d       = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         data_read_q <= 32'h0;
         off_q       <= '0;
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         data_read_q <= data_read_d;
         off_q       <= off_d;
      end
   end

   // RAM keeps its contents across reset; an edge seen with reset high drops the pending write.
   always_ff @(posedge clk_sys) begin
      if (wr_en && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (wb.sel[i]) begin
               ram_q[off_q][8*i +: 8] <= wb.data_write[8*i +: 8];
            end
         end
      end
   end

   assign wb.ack       = ack_q;
   assign wb.err       = err_q;
   assign wb.data_read = data_read_q;
endmodule

// File: tb/tb_apf_wishbone_slave.sv
// tb/tb_apf_wishbone_slave.sv - self-checking bench for apf_wishbone_slave
module tb_apf_wishbone_slave;
   localparam int          AW    = 8;
   localparam int          DEPTH = 1 << AW;
   localparam logic [29:0] BASE  = 30'h0000_0300;

   logic clk_sys = 1'b0;
   logic reset   = 1'b0;
   always #5 clk_sys = ~clk_sys;

   apf_wishbone_slave_if bus();

   apf_wishbone_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk_sys(clk_sys),
      .reset  (reset),
      .wb     (bus)
   );

   logic [31:0] model [DEPTH];
   int n_cmp  = 0;
   int n_fail = 0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
      return (old & ~m) | (d & m);
   endfunction

   function automatic logic in_window(input logic [29:0] a);
      return (a >= BASE) && (a < BASE + 30'(DEPTH));
   endfunction

   task automatic idle_bus();
      bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.sel = 0;
      bus.cti = 0; bus.bte = 0; bus.addr = 0; bus.data_write = 0;
   endtask

   task automatic xfer(input logic [29:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                       output int lat, output logic got_ack, output logic got_err, output logic [31:0] rd);
      @(posedge clk_sys); #1;
      bus.addr = a; bus.we = w; bus.sel = s; bus.data_write = d; bus.cti = 3'b000;
      bus.cyc = 1; bus.stb = 1;
      lat = 0; got_ack = 0; got_err = 0; rd = '0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk_sys);
         if (bus.ack === 1'b1 || bus.err === 1'b1) begin
            lat = i; got_ack = bus.ack; got_err = bus.err; rd = bus.data_read;
            break;
         end
      end
      @(posedge clk_sys); #1;
      idle_bus();
   endtask

   task automatic test_reset();
      idle_bus();
      #2 reset = 1'b1;
      #20;
      n_cmp++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
      n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
      n_cmp++; if (bus.data_read !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.data_read); end
      @(negedge clk_sys); reset = 1'b0;
   endtask

   task automatic test_init();
      int lat; logic ga, ge; logic [31:0] rd, d; int bad = 0;
      for (int off = 0; off < DEPTH; off++) begin
         d = $urandom;
         xfer(BASE + 30'(off), 1'b1, 4'hF, d, lat, ga, ge, rd);
         if (lat != 2 || ga !== 1'b1 || ge !== 1'b0) bad++;
         model[off] = d;
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL init_acks: got %0d bad writes expected 0", bad); end
   endtask

   task automatic test_classic();
      int lat; logic ga, ge; logic [31:0] rd;
      xfer(BASE + 30'd5, 1'b1, 4'hF, 32'hDEADBEEF, lat, ga, ge, rd);
      model[5] = 32'hDEADBEEF;
      n_cmp++; if (lat != 2 || ga !== 1'b1) begin n_fail++; $display("FAIL classic_wr_lat: got lat %0d ack %b expected 2/1", lat, ga); end
      n_cmp++; if (ge !== 1'b0) begin n_fail++; $display("FAIL classic_wr_err: got %b expected 0", ge); end
      @(negedge clk_sys);
      n_cmp++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL classic_ack_width: got %b expected 0", bus.ack); end
      xfer(BASE + 30'd5, 1'b0, 4'hF, 32'h0, lat, ga, ge, rd);
      n_cmp++; if (lat != 2 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL classic_rd: got lat %0d data %h expected 2/deadbeef", lat, rd); end
   endtask

   task automatic test_byte_lanes();
      int lat; logic ga, ge; logic [31:0] rd;
      xfer(BASE + 30'd2, 1'b1, 4'hF, 32'h11223344, lat, ga, ge, rd);
      xfer(BASE + 30'd2, 1'b1, 4'b0101, 32'hAABBCCDD, lat, ga, ge, rd);
      xfer(BASE + 30'd7, 1'b1, 4'h0, 32'hFFFFFFFF, lat, ga, ge, rd);
      n_cmp++; if (ga !== 1'b1) begin n_fail++; $display("FAIL sel0_ack: got %b expected 1", ga); end
      model[2] = 32'h11BB33DD;
      xfer(BASE + 30'd2, 1'b0, 4'hF, 32'h0, lat, ga, ge, rd);
      n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_lanes: got %h expected 11bb33dd", rd); end
      xfer(BASE + 30'd7, 1'b0, 4'hF, 32'h0, lat, ga, ge, rd);
      n_cmp++; if (rd !== model[7]) begin n_fail++; $display("FAIL sel0_nochange: got %h expected %h", rd, model[7]); end
   endtask

   task automatic test_miss();
      int lat; logic ga, ge; logic [31:0] rd;
      logic [29:0] addrs [2];
      addrs[0] = BASE + 30'(DEPTH);
      addrs[1] = BASE - 30'd1;
      for (int k = 0; k < 2; k++) begin
         xfer(addrs[k], 1'b1, 4'hF, $urandom, lat, ga, ge, rd);
         n_cmp++; if (lat != 2 || ge !== 1'b1) begin n_fail++; $display("FAIL miss_err: got lat %0d err %b expected 2/1", lat, ge); end
         n_cmp++; if (ga !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL miss_ack_data: got ack %b data %h expected 0/0", ga, rd); end
         @(negedge clk_sys);
         n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL miss_err_width: got %b expected 0", bus.err); end
         xfer(BASE + 30'(addrs[k] % DEPTH), 1'b0, 4'hF, 32'h0, lat, ga, ge, rd);
         n_cmp++; if (rd !== model[addrs[k] % DEPTH]) begin n_fail++; $display("FAIL miss_ram: got %h expected %h", rd, model[addrs[k] % DEPTH]); end
      end
   endtask

   task automatic test_held();
      int lat; logic ga, ge; logic [31:0] rd; logic [4:0] pat; logic [31:0] dc [5];
      int off = $urandom_range(0, DEPTH-1);
      @(posedge clk_sys); #1;
      bus.addr = BASE + 30'(off); bus.we = 1; bus.cyc = 1; bus.stb = 1;
      for (int c = 1; c <= 5; c++) begin
         if (c <= 4) begin
            dc[c] = $urandom; bus.sel = 4'b0001 << (c-1); bus.data_write = dc[c];
         end else begin
            idle_bus();
         end
         @(negedge clk_sys);
         pat[5-c] = bus.ack;
         @(posedge clk_sys); #1;
      end
      n_cmp++; if (pat !== 5'b01010) begin n_fail++; $display("FAIL held_ack_pattern: got %b expected 01010", pat); end
      model[off] = merge(merge(model[off], dc[2], 4'b0010), dc[4], 4'b1000);
      xfer(BASE + 30'(off), 1'b0, 4'hF, 32'h0, lat, ga, ge, rd);
      n_cmp++; if (rd !== model[off]) begin n_fail++; $display("FAIL held_writes: got %h expected %h", rd, model[off]); end
   endtask

   task automatic test_cyc_drop();
      int lat; logic ga, ge; logic [31:0] rd;
      int off = $urandom_range(0, DEPTH-1);
      @(posedge clk_sys); #1;
      bus.addr = BASE + 30'(off); bus.we = 1; bus.sel = 4'hF; bus.data_write = ~model[off];
      bus.cyc = 1; bus.stb = 1;
      @(posedge clk_sys); #1;
      bus.cyc = 0;
      @(negedge clk_sys);
      n_cmp++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL cycdrop_ack: got %b expected 1", bus.ack); end
      @(posedge clk_sys); #1;
      idle_bus();
      @(negedge clk_sys);
      n_cmp++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL cycdrop_ack_low: got %b expected 0", bus.ack); end
      xfer(BASE + 30'(off), 1'b0, 4'hF, 32'h0, lat, ga, ge, rd);
      n_cmp++; if (rd !== model[off]) begin n_fail++; $display("FAIL cycdrop_nowrite: got %h expected %h", rd, model[off]); end
   endtask

   task automatic test_reset_mid();
      int off = $urandom_range(0, DEPTH-1);
      @(posedge clk_sys); #1;
      bus.addr = BASE + 30'(off); bus.we = 1; bus.sel = 4'hF; bus.data_write = ~model[off];
      bus.cyc = 1; bus.stb = 1;
      @(negedge clk_sys);
      @(negedge clk_sys);
      n_cmp++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_ack: got %b expected 1", bus.ack); end
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (bus.ack !== 1'b0 || bus.data_read !== 32'h0) begin n_fail++; $display("FAIL rstmid_async: got ack %b data %h expected 0/0", bus.ack, bus.data_read); end
      bus.we = 1'b0;
      @(posedge clk_sys);
      @(negedge clk_sys); reset = 1'b0;
      @(negedge clk_sys);
      n_cmp++; if (bus.ack !== 1'b1 || bus.data_read !== model[off]) begin n_fail++; $display("FAIL rstmid_after: got ack %b data %h expected 1/%h", bus.ack, bus.data_read, model[off]); end
      @(posedge clk_sys); #1;
      idle_bus();
   endtask

   task automatic test_random();
      int lat; logic ga, ge; logic [31:0] rd, d; logic [29:0] a; logic w, miss; logic [3:0] s;
      for (int n = 0; n < 60; n++) begin
         miss = ($urandom_range(0, 5) == 0);
         if (!miss) a = BASE + 30'($urandom_range(0, DEPTH-1));
         else if ($urandom_range(0, 1) == 1) a = BASE + 30'(DEPTH) + 30'($urandom_range(0, 999));
         else a = BASE - 30'd1 - 30'($urandom_range(0, 255));
         w = 1'($urandom_range(0, 1)); s = 4'($urandom); d = $urandom;
         xfer(a, w, s, d, lat, ga, ge, rd);
         n_cmp++; if (lat != 2 || ge !== !in_window(a) || ga !== in_window(a)) begin
            n_fail++; $display("FAIL rand_term[%0d]: got lat %0d ack %b err %b expected 2/%b/%b", n, lat, ga, ge, in_window(a), !in_window(a));
         end
         if (!in_window(a)) begin
            n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rand_err_data[%0d]: got %h expected 0", n, rd); end
         end else if (!w) begin
            n_cmp++; if (rd !== model[a - BASE]) begin n_fail++; $display("FAIL rand_read[%0d]: got %h expected %h", n, rd, model[a - BASE]); end
         end else begin
            model[a - BASE] = merge(model[a - BASE], d, s);
         end
      end
   endtask

`ifdef APF_WB_SLAVE_BURST_EN
   task automatic test_burst();
      int lat; logic ga, ge; logic [31:0] rd; logic [5:0] av; logic [31:0] rv [7]; logic [31:0] wd [3];
      int offs [4];
      offs[0] = 254; offs[1] = 255; offs[2] = 0; offs[3] = 1;
      @(posedge clk_sys); #1;
      bus.addr = BASE + 30'd254; bus.we = 0; bus.sel = 4'hF; bus.cti = 3'b010; bus.bte = 2'b00;
      bus.cyc = 1; bus.stb = 1;
      for (int c = 1; c <= 6; c++) begin
         if (c == 5) bus.cti = 3'b111;
         if (c == 6) idle_bus();
         @(negedge clk_sys);
         av[6-c] = bus.ack; rv[c] = bus.data_read;
         n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL burst_err[%0d]: got %b expected 0", c, bus.err); end
         @(posedge clk_sys); #1;
      end
      n_cmp++; if (av !== 6'b011110) begin n_fail++; $display("FAIL burst_rd_acks: got %b expected 011110", av); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (rv[k+2] !== model[offs[k]]) begin n_fail++; $display("FAIL burst_rd_beat%0d: got %h expected %h", k, rv[k+2], model[offs[k]]); end
      end
      for (int k = 0; k < 3; k++) wd[k] = $urandom;
      bus.addr = BASE + 30'd10; bus.we = 1; bus.sel = 4'hF; bus.cti = 3'b010; bus.bte = 2'b00;
      bus.cyc = 1; bus.stb = 1;
      for (int c = 1; c <= 5; c++) begin
         if (c <= 2) bus.data_write = wd[0];
         if (c == 3) bus.data_write = wd[1];
         if (c == 4) begin bus.data_write = wd[2]; bus.cti = 3'b111; end
         if (c == 5) idle_bus();
         @(negedge clk_sys);
         av[5-c] = bus.ack;
         @(posedge clk_sys); #1;
      end
      n_cmp++; if (av[4:0] !== 5'b01110) begin n_fail++; $display("FAIL burst_wr_acks: got %b expected 01110", av[4:0]); end
      for (int k = 0; k < 3; k++) begin
         model[10+k] = wd[k];
         xfer(BASE + 30'(10+k), 1'b0, 4'hF, 32'h0, lat, ga, ge, rd);
         n_cmp++; if (rd !== wd[k]) begin n_fail++; $display("FAIL burst_wr_beat%0d: got %h expected %h", k, rd, wd[k]); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_init();
      test_classic();
      test_byte_lanes();
      test_miss();
      test_held();
      test_cyc_drop();
      test_reset_mid();
      test_random();
`ifdef APF_WB_SLAVE_BURST_EN
      test_burst();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
